ps2_key_state_tracker: RTL and testbench

Upstream stage of the master FSM. Consumes decoded PS/2 set-2 bytes from the PS/2 receiver and turns make/break sequences into the level-held key vector inputStateStorage, one bit per tracked key. It also emits a one-cycle key event strobe with an index and a press/release flag, which the note recorder uses. Prefixes are tracked by a small FSM with a timeout, so a lost byte cannot leave the tracker stuck.

---
 rtl/ps2_key_state_tracker_pkg.sv | 42 ++++
 rtl/ps2_scancode_lookup.sv | 36 +++
 rtl/ps2_key_state_tracker.sv | 146 ++++++++++++++
 tb/tb_ps2_key_state_tracker.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ps2_key_state_tracker_pkg.sv
// Shared constants for the PS/2 key tracker: key indices, set-2 scancodes and FSM states.
package ps2_key_state_tracker_pkg;

  localparam int unsigned NUMBEROFKEYBOARDINPUTS = 16;
  localparam int unsigned KEY_IDX_W              = 4;
  localparam int unsigned DEFAULT_PREFIX_TIMEOUT = 2500000;

  // Bit positions in inputStateStorage
  localparam int unsigned KEY_SPACEBAR = 0;
  localparam int unsigned KEY_ENTER    = 1;
  localparam int unsigned KEY_R        = 2;
  localparam int unsigned KEY_A        = 3;
  localparam int unsigned KEY_S        = 4;
  localparam int unsigned KEY_D        = 5;
  localparam int unsigned KEY_F        = 6;
  localparam int unsigned KEY_G        = 7;
  localparam int unsigned KEY_H        = 8;
  localparam int unsigned KEY_J        = 9;
  localparam int unsigned KEY_K        = 10;
  localparam int unsigned KEY_W        = 11;
  localparam int unsigned KEY_E        = 12;
  localparam int unsigned KEY_T        = 13;
  localparam int unsigned KEY_Y        = 14;
  localparam int unsigned KEY_U        = 15;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Pause is E1 followed by seven more bytes
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BREAK     = 3'd1,
    ST_EXT       = 3'd2,
    ST_EXT_BREAK = 3'd3,
    ST_SKIP      = 3'd4
  } state_e;

endpackage

// File: rtl/ps2_scancode_lookup.sv
// Combinational map from an unprefixed set-2 scancode to a tracked key index.
module ps2_scancode_lookup
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int unsigned IDX_W = KEY_IDX_W
) (
  input  logic [7:0]       ps2ByteIn,
  output logic             hit_c,
  output logic [IDX_W-1:0] index_c
);

  always_comb begin
    hit_c   = 1'b1;
    index_c = '0;
    case (ps2ByteIn)
      8'h29:   index_c = IDX_W'(KEY_SPACEBAR);
      8'h5A:   index_c = IDX_W'(KEY_ENTER);
      8'h2D:   index_c = IDX_W'(KEY_R);
      8'h1C:   index_c = IDX_W'(KEY_A);
      8'h1B:   index_c = IDX_W'(KEY_S);
      8'h23:   index_c = IDX_W'(KEY_D);
      8'h2B:   index_c = IDX_W'(KEY_F);
      8'h34:   index_c = IDX_W'(KEY_G);
      8'h33:   index_c = IDX_W'(KEY_H);
      8'h3B:   index_c = IDX_W'(KEY_J);
      8'h42:   index_c = IDX_W'(KEY_K);
      8'h1D:   index_c = IDX_W'(KEY_W);
      8'h24:   index_c = IDX_W'(KEY_E);
      8'h2C:   index_c = IDX_W'(KEY_T);
      8'h35:   index_c = IDX_W'(KEY_Y);
      8'h3C:   index_c = IDX_W'(KEY_U);
      default: hit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_state_tracker.sv
// Turns PS/2 make/break byte sequences into a held-key vector plus a one-cycle key event.
module ps2_key_state_tracker
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = NUMBEROFKEYBOARDINPUTS,
  parameter int unsigned IDX_W          = KEY_IDX_W,
  parameter int unsigned PREFIX_TIMEOUT = DEFAULT_PREFIX_TIMEOUT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          ps2ByteIn,
  input  logic                ps2ByteValid,
  output logic [NUM_KEYS-1:0] inputStateStorage,
  output logic                keyEvent,
  output logic [IDX_W-1:0]    keyEventIndex,
  output logic                keyEventIsPress
);

  localparam int unsigned TMO_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic                ev_q, ev_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                press_q, press_d;

  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic                do_make, do_break;
  logic [IDX_W-1:0]    key_idx;

  ps2_scancode_lookup #(.IDX_W(IDX_W)) u_lookup (
    .ps2ByteIn (ps2ByteIn),
    .hit_c     (lk_hit),
    .index_c   (lk_idx)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
      keys_q  <= '0;
      ev_q    <= 1'b0;
      idx_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      keys_q  <= keys_d;
      ev_q    <= ev_d;
      idx_q   <= idx_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    keys_d   = keys_q;
    ev_d     = 1'b0;
    idx_d    = idx_q;
    press_d  = press_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    key_idx  = lk_idx;

    if (ps2ByteValid) begin
      // A byte always beats an expiring timeout
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (ps2ByteIn == SC_BREAK) begin
            state_d = ST_BREAK;
          end else if (ps2ByteIn == SC_EXT) begin
            state_d = ST_EXT;
          end else if (ps2ByteIn == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LEN;
          end else begin
            do_make = lk_hit;
          end
        end
        ST_BREAK: begin
          state_d  = ST_IDLE;
          do_break = lk_hit;
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          key_idx = IDX_W'(KEY_ENTER);
          if (ps2ByteIn == SC_BREAK) begin
            state_d = ST_EXT_BREAK;
          end else begin
            do_make = (ps2ByteIn == SC_ENTER);
          end
        end
        ST_EXT_BREAK: begin
          state_d  = ST_IDLE;
          key_idx  = IDX_W'(KEY_ENTER);
          do_break = (ps2ByteIn == SC_ENTER);
        end
        ST_SKIP: begin
          if (skip_q <= 3'd1) begin
            state_d = ST_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q >= TMO_LAST) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
        skip_d  = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    // Typematic repeats and breaks of released keys produce no event
    if (do_make && !keys_q[key_idx]) begin
      keys_d[key_idx] = 1'b1;
      ev_d            = 1'b1;
      idx_d           = key_idx;
      press_d         = 1'b1;
    end else if (do_break && keys_q[key_idx]) begin
      keys_d[key_idx] = 1'b0;
      ev_d            = 1'b1;
      idx_d           = key_idx;
      press_d         = 1'b0;
    end
  end

  assign inputStateStorage = keys_q;
  assign keyEvent          = ev_q;
  assign keyEventIndex     = idx_q;
  assign keyEventIsPress   = press_q;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Directed vector bench for ps2_key_state_tracker, run with a short prefix timeout.
module tb_ps2_key_state_tracker;

  localparam int unsigned TMO = 5;

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  b;
    logic [15:0] k;
    logic        e;
    logic [3:0]  i;
    logic        p;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  ps2ByteIn;
  logic        ps2ByteValid;
  logic [15:0] inputStateStorage;
  logic        keyEvent;
  logic [3:0]  keyEventIndex;
  logic        keyEventIsPress;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ps2_key_state_tracker #(
    .NUM_KEYS       (16),
    .IDX_W          (4),
    .PREFIX_TIMEOUT (TMO)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ps2ByteIn         (ps2ByteIn),
    .ps2ByteValid      (ps2ByteValid),
    .inputStateStorage (inputStateStorage),
    .keyEvent          (keyEvent),
    .keyEventIndex     (keyEventIndex),
    .keyEventIsPress   (keyEventIsPress)
  );

  task automatic add(input logic r, input logic v, input logic [7:0] b, input logic [15:0] k,
                     input logic e, input logic [3:0] i, input logic p);
    vec_t x;
    x.r = r; x.v = v; x.b = b; x.k = k; x.e = e; x.i = i; x.p = p;
    tbl.push_back(x);
  endtask

  // Drive one cycle, then compare the registered outputs just after the edge
  task automatic step(input string nm, input logic r, input logic v, input logic [7:0] b,
                      input logic [15:0] k, input logic e, input logic [3:0] i, input logic p);
    @(negedge clk);
    resetn       = r;
    ps2ByteValid = v;
    ps2ByteIn    = b;
    @(posedge clk);
    #1;
    checks++;
    if (inputStateStorage !== k) begin
      errors++;
      $display("FAIL %s keys: got %h expected %h", nm, inputStateStorage, k);
    end
    checks++;
    if (keyEvent !== e) begin
      errors++;
      $display("FAIL %s keyEvent: got %b expected %b", nm, keyEvent, e);
    end
    if (e || r) begin
      checks++;
      if (keyEventIndex !== i || keyEventIsPress !== p) begin
        errors++;
        $display("FAIL %s index/press: got %0d/%b expected %0d/%b",
                 nm, keyEventIndex, keyEventIsPress, i, p);
      end
    end
  endtask

  task automatic idle(input string nm, input int n, input logic [15:0] k);
    for (int c = 0; c < n; c++) step(nm, 1'b0, 1'b0, 8'h00, k, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    resetn       = 1'b1;
    ps2ByteValid = 1'b0;
    ps2ByteIn    = 8'h00;

    // reset, spacebar
    add(1, 0, 8'h00, 16'h0000, 0, 4'd0,  0);
    add(0, 1, 8'h29, 16'h0001, 1, 4'd0,  1);
    add(0, 0, 8'h00, 16'h0001, 0, 4'd0,  0);
    // typematic A then release
    add(0, 1, 8'h1C, 16'h0009, 1, 4'd3,  1);
    add(0, 1, 8'h1C, 16'h0009, 0, 4'd0,  0);
    add(0, 1, 8'h1C, 16'h0009, 0, 4'd0,  0);
    add(0, 1, 8'hF0, 16'h0009, 0, 4'd0,  0);
    add(0, 1, 8'h1C, 16'h0001, 1, 4'd3,  0);
    // extended Enter make/break, unknown extended, then W proves IDLE
    add(0, 1, 8'hE0, 16'h0001, 0, 4'd0,  0);
    add(0, 1, 8'h5A, 16'h0003, 1, 4'd1,  1);
    add(0, 1, 8'hE0, 16'h0003, 0, 4'd0,  0);
    add(0, 1, 8'hF0, 16'h0003, 0, 4'd0,  0);
    add(0, 1, 8'h5A, 16'h0001, 1, 4'd1,  0);
    add(0, 1, 8'hE0, 16'h0001, 0, 4'd0,  0);
    add(0, 1, 8'h75, 16'h0001, 0, 4'd0,  0);
    add(0, 1, 8'h1D, 16'h0801, 1, 4'd11, 1);
    // S and D, release only S
    add(0, 1, 8'h1B, 16'h0811, 1, 4'd4,  1);
    add(0, 1, 8'h23, 16'h0831, 1, 4'd5,  1);
    add(0, 1, 8'hF0, 16'h0831, 0, 4'd0,  0);
    add(0, 1, 8'h1B, 16'h0821, 1, 4'd4,  0);
    // Pause sequence then R
    add(0, 1, 8'hE1, 16'h0821, 0, 4'd0,  0);
    add(0, 1, 8'h14, 16'h0821, 0, 4'd0,  0);
    add(0, 1, 8'h77, 16'h0821, 0, 4'd0,  0);
    add(0, 1, 8'hE1, 16'h0821, 0, 4'd0,  0);
    add(0, 1, 8'hF0, 16'h0821, 0, 4'd0,  0);
    add(0, 1, 8'h14, 16'h0821, 0, 4'd0,  0);
    add(0, 1, 8'hF0, 16'h0821, 0, 4'd0,  0);
    add(0, 1, 8'h77, 16'h0821, 0, 4'd0,  0);
    add(0, 1, 8'h2D, 16'h0825, 1, 4'd2,  1);
    // break of a key not held, then spacebar break
    add(0, 1, 8'hF0, 16'h0825, 0, 4'd0,  0);
    add(0, 1, 8'h2B, 16'h0825, 0, 4'd0,  0);
    add(0, 1, 8'hF0, 16'h0825, 0, 4'd0,  0);
    add(0, 1, 8'h29, 16'h0824, 1, 4'd0,  0);

    for (int n = 0; n < tbl.size(); n++)
      step($sformatf("vec%0d", n), tbl[n].r, tbl[n].v, tbl[n].b, tbl[n].k, tbl[n].e, tbl[n].i, tbl[n].p);

    // prefix expires: 23 becomes a make of held D, then S make proves IDLE
    step("tmo_f0", 0, 1, 8'hF0, 16'h0824, 0, 4'd0, 0);
    idle("tmo_wait", 8, 16'h0824);
    step("tmo_23", 0, 1, 8'h23, 16'h0824, 0, 4'd0, 0);
    step("tmo_s", 0, 1, 8'h1B, 16'h0834, 1, 4'd4, 1);

    // byte arrives in the expiry cycle: still a break
    step("edge_f0", 0, 1, 8'hF0, 16'h0834, 0, 4'd0, 0);
    idle("edge_wait", TMO - 1, 16'h0834);
    step("edge_1b", 0, 1, 8'h1B, 16'h0824, 1, 4'd4, 0);

    // one cycle later the prefix is gone: a make
    step("late_f0", 0, 1, 8'hF0, 16'h0824, 0, 4'd0, 0);
    idle("late_wait", TMO, 16'h0824);
    step("late_1b", 0, 1, 8'h1B, 16'h0834, 1, 4'd4, 1);

    // reset after F0 discards the prefix
    step("rst_g", 0, 1, 8'h34, 16'h08B4, 1, 4'd7, 1);
    step("rst_f0", 0, 1, 8'hF0, 16'h08B4, 0, 4'd0, 0);
    step("rst_apply", 1, 0, 8'h00, 16'h0000, 0, 4'd0, 0);
    step("rst_g2", 0, 1, 8'h34, 16'h0080, 1, 4'd7, 1);
    step("rst_hold", 0, 0, 8'h00, 16'h0080, 0, 4'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
